// File: rtl/simd2_pkg.sv
// Shared types and constants for the simd2 datapath.
package simd2_pkg;

    localparam int SIMD2_LANES = 10;
    localparam int SIMD2_W     = 16;

    typedef logic [1:0] opcode_t;

    typedef enum logic [1:0] {
        IDLE,
        SEND,
        SUM
    } state_t;

endpackage

// File: rtl/simd2_lane_serializer_if.sv
// Capture port plus serial lane/sum port of the lane serializer.
interface simd2_lane_serializer_if
    import simd2_pkg::*;
#(
    parameter int LANES = SIMD2_LANES,
    parameter int W     = SIMD2_W
);

    logic               in_valid;
    logic               in_ready;
    logic [LANES*W-1:0] in_lanes;
    opcode_t            in_opcode;

    logic               out_valid;
    logic               out_ready;
    logic [W-1:0]       out_data;
    logic [3:0]         out_lane;
    logic               out_last;
    opcode_t            out_opcode;

    logic               sum_valid;
    logic [W+3:0]       sum_out;

    modport master (
        output in_valid, in_lanes, in_opcode, out_ready,
        input  in_ready, out_valid, out_data, out_lane,
        input  out_last, out_opcode, sum_valid, sum_out
    );

    modport slave (
        input  in_valid, in_lanes, in_opcode, out_ready,
        output in_ready, out_valid, out_data, out_lane,
        output out_last, out_opcode, sum_valid, sum_out
    );

endinterface

// File: rtl/simd2_lane_serializer.sv
// Captures one wide simd2 result and streams it out lane by lane,
// then reports the unsigned sum of all lanes.
module simd2_lane_serializer
    import simd2_pkg::*;
#(
    parameter int LANES = SIMD2_LANES,
    parameter int W     = SIMD2_W
) (
    input  logic                  clk,
    input  logic                  rst,
    simd2_lane_serializer_if.slave bus
);

    localparam int SW = W + 4;

    state_t       r_state;
    state_t       w_next;
    logic [3:0]   r_idx;
    logic [W-1:0] r_buf [LANES];
    opcode_t      r_opcode;
    logic [SW-1:0] r_acc;
    logic [SW-1:0] r_sum;

    logic          w_capture;
    logic          w_accept;
    logic          w_last;
    logic          w_send;
    logic [W-1:0]  w_lane;
    logic [SW-1:0] w_acc_next;

    assign w_send     = (r_state == SEND);
    assign w_capture  = (r_state == IDLE) && bus.in_valid;
    assign w_accept   = w_send && bus.out_ready;
    assign w_last     = (r_idx == 4'(LANES - 1));
    assign w_lane     = r_buf[r_idx];
    assign w_acc_next = r_acc + SW'(w_lane);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            IDLE: if (bus.in_valid) w_next = SEND;
            SEND: if (w_accept && w_last) w_next = SUM;
            SUM:  w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // Final sum lands in r_sum on the last handshake so it is valid in SUM.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_idx    <= '0;
            r_opcode <= '0;
            r_acc    <= '0;
            r_sum    <= '0;
        end else if (w_capture) begin
            r_idx    <= '0;
            r_opcode <= bus.in_opcode;
            r_acc    <= '0;
        end else if (w_accept) begin
            r_acc <= w_acc_next;
            if (w_last) begin
                r_sum <= w_acc_next;
            end else begin
                r_idx <= r_idx + 4'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_capture) begin
            for (int k = 0; k < LANES; k++) begin
                r_buf[k] <= bus.in_lanes[k*W +: W];
            end
        end
    end

    assign bus.in_ready   = (r_state == IDLE);
    assign bus.out_valid  = w_send;
    assign bus.sum_valid  = (r_state == SUM);
    assign bus.out_data   = w_send ? w_lane : '0;
    assign bus.out_lane   = w_send ? r_idx : '0;
    assign bus.out_last   = w_send && w_last;
    assign bus.out_opcode = r_opcode;
    assign bus.sum_out    = r_sum;

endmodule

// File: tb/tb_simd2_lane_serializer.sv
// Self-checking bench: table vectors, corner sequences and random
// bursts against a lane-list/sum reference model.
module tb_simd2_lane_serializer;
    import simd2_pkg::*;

    localparam int L = 10;
    localparam int W = 16;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    simd2_lane_serializer_if bus ();

    simd2_lane_serializer dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_checks = 0;
    int n_err    = 0;

    typedef struct {
        logic [L*W-1:0] lanes;
        logic [1:0]     op;
        int             mode;
        logic [19:0]    sum;
    } vec_t;

    vec_t tv [4];

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [19:0] model_sum(input logic [L*W-1:0] v);
        logic [19:0] s = '0;
        for (int k = 0; k < L; k++) s += 20'(v[k*W +: W]);
        return s;
    endfunction

    task automatic capture(input logic [L*W-1:0] lanes, input logic [1:0] op);
        int t = 0;
        while (bus.in_ready !== 1'b1 && t < 40) begin
            step();
            t++;
        end
        chk("cap_wait_in_ready", 32'(bus.in_ready), 32'd1);
        bus.in_valid  = 1'b1;
        bus.in_lanes  = lanes;
        bus.in_opcode = op;
        step();
        bus.in_valid = 1'b0;
    endtask

    // mode 0: always ready, 1: toggled, 2: random
    task automatic drain(input logic [L*W-1:0] lanes, input logic [1:0] op,
                         input int mode, input logic [19:0] exp_sum,
                         input bit intrude, input logic [L*W-1:0] other);
        int k = 0;
        int cyc = 0;
        logic rdy;
        if (intrude) begin
            bus.in_valid  = 1'b1;
            bus.in_lanes  = other;
            bus.in_opcode = ~op;
        end
        while (k < L && cyc < 300) begin
            if (mode == 0) rdy = 1'b1;
            else if (mode == 1) rdy = (cyc % 2 == 0);
            else rdy = 1'($urandom % 2);
            bus.out_ready = rdy;
            chk("out_valid", 32'(bus.out_valid), 32'd1);
            chk("out_data", 32'(bus.out_data), 32'(lanes[k*W +: W]));
            chk("out_lane", 32'(bus.out_lane), 32'(k));
            chk("out_last", 32'(bus.out_last), 32'(k == L - 1));
            chk("out_opcode", 32'(bus.out_opcode), 32'(op));
            chk("sum_valid_in_send", 32'(bus.sum_valid), 32'd0);
            chk("in_ready_in_send", 32'(bus.in_ready), 32'd0);
            if (rdy) k++;
            step();
            cyc++;
        end
        if (k < L) chk("drain_timeout", 32'(k), 32'(L));
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        if (mode == 0) chk("zero_stall_cycles", 32'(cyc), 32'(L));
        chk("sum_valid_pulse", 32'(bus.sum_valid), 32'd1);
        chk("sum_out", 32'(bus.sum_out), 32'(exp_sum));
        chk("out_valid_in_sum", 32'(bus.out_valid), 32'd0);
        chk("in_ready_in_sum", 32'(bus.in_ready), 32'd0);
        step();
        chk("sum_valid_single", 32'(bus.sum_valid), 32'd0);
        chk("in_ready_after_sum", 32'(bus.in_ready), 32'd1);
        chk("sum_out_hold", 32'(bus.sum_out), 32'(exp_sum));
    endtask

    initial begin
        logic [L*W-1:0] a;
        logic [L*W-1:0] b;
        logic [1:0] op;
        int cyc;
        int hits;

        for (int k = 0; k < L; k++) begin
            tv[0].lanes[k*W +: W] = 16'(k + 1);
            tv[1].lanes[k*W +: W] = 16'hFFFF;
            tv[2].lanes[k*W +: W] = 16'(16'h0100 * k);
            tv[3].lanes[k*W +: W] = 16'(16'hFFFF - k);
            b[k*W +: W] = 16'hAAAA;
        end
        tv[0].op = 2'b01; tv[0].mode = 0; tv[0].sum = 20'h00037;
        tv[1].op = 2'b10; tv[1].mode = 0; tv[1].sum = 20'h9FFF6;
        tv[2].op = 2'b11; tv[2].mode = 1; tv[2].sum = 20'h02D00;
        tv[3].op = 2'b00; tv[3].mode = 1; tv[3].sum = 20'h9FFC9;

        rst = 1'b1;
        bus.in_valid  = 1'b0;
        bus.in_lanes  = '0;
        bus.in_opcode = '0;
        bus.out_ready = 1'b0;
        step(); step(); step();
        chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
        chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_sum_valid", 32'(bus.sum_valid), 32'd0);
        chk("rst_sum_out", 32'(bus.sum_out), 32'd0);
        chk("rst_out_data", 32'(bus.out_data), 32'd0);
        chk("rst_out_lane", 32'(bus.out_lane), 32'd0);
        chk("rst_out_last", 32'(bus.out_last), 32'd0);
        chk("rst_out_opcode", 32'(bus.out_opcode), 32'd0);
        rst = 1'b0;
        step();

        for (int i = 0; i < 4; i++) begin
            capture(tv[i].lanes, tv[i].op);
            drain(tv[i].lanes, tv[i].op, tv[i].mode, tv[i].sum, 1'b0, '0);
        end

        // in_valid during SEND is ignored, then captured from IDLE
        capture(tv[0].lanes, tv[0].op);
        drain(tv[0].lanes, tv[0].op, 0, 20'h00037, 1'b1, b);
        capture(b, 2'b10);
        drain(b, 2'b10, 0, 20'h6AAA4, 1'b0, '0);

        // reset mid-burst after lane 4 accepted
        capture(tv[0].lanes, tv[0].op);
        bus.out_ready = 1'b1;
        for (int i = 0; i < 5; i++) step();
        chk("mid_lane_before_rst", 32'(bus.out_lane), 32'd5);
        rst = 1'b1;
        step();
        chk("mrst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("mrst_in_ready", 32'(bus.in_ready), 32'd1);
        chk("mrst_out_data", 32'(bus.out_data), 32'd0);
        chk("mrst_out_opcode", 32'(bus.out_opcode), 32'd0);
        chk("mrst_sum_out", 32'(bus.sum_out), 32'd0);
        rst = 1'b0;
        hits = 0;
        for (int i = 0; i < 15; i++) begin
            if (bus.sum_valid === 1'b1) hits++;
            step();
        end
        chk("mrst_no_sum_valid", 32'(hits), 32'd0);
        bus.out_ready = 1'b0;
        capture(tv[2].lanes, 2'b11);
        drain(tv[2].lanes, 2'b11, 0, 20'h02D00, 1'b0, '0);

        for (int r = 0; r < 6; r++) begin
            for (int k = 0; k < L; k++) a[k*W +: W] = 16'($urandom);
            op = 2'($urandom);
            capture(a, op);
            drain(a, op, 2, model_sum(a), 1'b0, '0);
        end

        // back-to-back capture spacing with in_valid held high
        for (int k = 0; k < L; k++) a[k*W +: W] = 16'($urandom);
        chk("b2b_start_idle", 32'(bus.in_ready), 32'd1);
        bus.in_valid  = 1'b1;
        bus.in_lanes  = a;
        bus.in_opcode = 2'b01;
        bus.out_ready = 1'b1;
        step();
        cyc = 1;
        while (bus.in_ready !== 1'b1 && cyc < 40) begin
            step();
            cyc++;
        end
        chk("b2b_gap", 32'(cyc), 32'd12);
        step();
        bus.in_valid = 1'b0;
        drain(a, 2'b01, 0, model_sum(a), 1'b0, '0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule

// File: doc/simd2_lane_serializer.md
# simd2_lane_serializer

Downstream stage of the `simd2` datapath. It captures the ten 16-bit lane results of one SIMD operation in a single cycle. It then streams them out one lane per handshake on a valid/ready port, tagged with lane index, last flag and opcode, and reports the unsigned sum of all lanes when the burst completes. This lets the narrow writeback/debug path consume the wide `simd2` result without stalling the SIMD unit longer than one capture cycle.

## Interface
- `LANES`, 10, number of lanes captured per operation
- `W`, 16, lane width in bits
- `clk`  in  1  rising-edge clock
- `rst`  in  1  synchronous, active-high reset
- `in_valid`  in  1  lane vector and opcode are valid
- `in_ready`  out  1  block can capture; high only in IDLE
- `in_lanes`  in  LANES*W  lane k occupies bits [k*W +: W]; lane 0 = `output_one`, lane 9 = `output_ten`
- `in_opcode`  in  2  opcode that produced the lanes
- `out_valid`  out  1  `out_data` holds a valid lane
- `out_ready`  in  1  consumer accepts the current lane
- `out_data`  out  W  current lane value
- `out_lane`  out  4  index of the current lane, 0..LANES-1
- `out_last`  out  1  current lane is lane LANES-1
- `out_opcode`  out  2  captured opcode, constant for the whole burst
- `sum_valid`  out  1  one-cycle pulse; `sum_out` is final
- `sum_out`  out  W+4  unsigned sum of all LANES lanes of the last burst

## Operation
- FSM states and transitions:
  - IDLE: `in_ready`=1. On `in_valid`, capture all lanes and the opcode, clear `idx` and the accumulator, then go to SEND.
  - SEND: `out_valid`=1, `out_data`=buf[idx]. On `out_ready`, add buf[idx] to the accumulator. If idx==LANES-1, go to SUM; otherwise idx+1.
  - SUM: `sum_valid`=1 for exactly one cycle, `sum_out`=accumulator. Next state is IDLE.
- Arithmetic: zero-extend lanes to W+4 bits before adding. Worst case 10×0xFFFF = 0x9FFF6 fits, so the sum never overflows.
- `out_data`, `out_lane`, `out_last` and `out_opcode` stay stable while `out_valid && !out_ready`.
- `in_valid` outside IDLE is ignored; nothing is captured, no error is flagged, and the upstream holds its data.
- `sum_out` holds its last value until the next burst's SUM state. It reads 0 after reset.
- Reset: takes effect at any state, including mid-burst. The partial burst is discarded, with no `sum_valid`. All outputs go to 0 except `in_ready`=1. The buffer contents are don't-care.

## Timing
- Capture edge is cycle c. `out_valid` is high in cycle c+1 with lane 0.
- Zero-stall burst: lanes are on cycles c+1..c+10, `sum_valid` on c+11, and `in_ready` is high again in c+12. That gives 12 cycles per operation at minimum.
- Each cycle with `out_ready` low in SEND adds one cycle.
- `in_ready`, `out_valid` and `sum_valid` are registered state decodes with no combinational path from `out_ready`.
- `out_ready` asserted in IDLE or SUM has no effect.

## Structure
- Shared package `simd2_pkg` holds:
  - `SIMD2_LANES`=10 and `SIMD2_W`=16
  - the 2-bit opcode type
  - the state enum {IDLE, SEND, SUM}
- Single module, no sub-modules. The lane buffer is a LANES×W register array indexed by `idx`.

## Test plan
- Lanes k = k+1 (1..10), opcode 2'b01, `out_ready` held high:
  - outputs 1..10 on consecutive cycles, `out_lane` 0..9, `out_last` only on lane 9
  - `sum_out`=55 (0x00037) with a single `sum_valid` pulse
- All lanes 0xFFFF: `sum_out`=0x9FFF6, and no bit is lost.
- Lanes 0x0100*k with `out_ready` toggled every other cycle:
  - each lane is held stable until accepted, with no duplicate and no skip
  - `sum_out`=0x2D00
- Second `in_valid` asserted during SEND with different lanes: ignored, and the first burst completes unchanged. Presenting it again after IDLE captures the new data.
- `rst` pulsed after lane 4 is accepted:
  - next cycle `out_valid`=0, `in_ready`=1, `sum_valid` never asserts
  - a new burst then starts cleanly from lane 0
- Back-to-back operations with `in_valid` held high: the second capture occurs exactly 12 cycles after the first when there is no backpressure.
